// File: rtl/tpu_ctrl_pkg.sv
// Shared control-path definitions for the TPU sequencing blocks.
//   drain_state_e        : weight drain FSM states
//   DEFAULT_WIDTH_HEIGHT : default array edge / lane count
//   cnt_width()          : width of a counter spanning one skewed tile (2*WH-1 steps)
package tpu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } drain_state_e;

    localparam int unsigned DEFAULT_WIDTH_HEIGHT = 16;

    // Counter width able to hold 0 .. 2*wh-1.
    function automatic int unsigned cnt_width(input int unsigned wh);
        return $clog2(2 * wh);
    endfunction

endpackage

// File: rtl/skew_window_decode.sv
// Diagonal wavefront decode: lane i is wanted while cnt lies in [i, i+WH-1].
// Also used by the activation skew logic.
//   cnt    in  CNT_W  wavefront step
//   active in  1      enables the window (otherwise want = 0)
//   want   out WH     per-lane window membership
module skew_window_decode #(
    parameter int unsigned WIDTH_HEIGHT = 16,
    parameter int unsigned CNT_W        = 5
) (
    input  logic [CNT_W-1:0]        cnt,
    input  logic                    active,
    output logic [WIDTH_HEIGHT-1:0] want
);

    // One extra bit so i+WH-1 never wraps for the top lane.
    localparam int unsigned CMP_W = CNT_W + 1;

    logic [CMP_W-1:0] cnt_ext;

    always_comb begin
        want    = '0;
        cnt_ext = {1'b0, cnt};
        for (int unsigned i = 0; i < WIDTH_HEIGHT; i++) begin
            want[i] = active
                   && (cnt_ext >= CMP_W'(i))
                   && (cnt_ext <= CMP_W'(i + WIDTH_HEIGHT - 1));
        end
    end

endmodule

// File: rtl/weight_fifo_drain_control.sv
// Drains one full tile from the per-column weight FIFOs into the systolic array,
// popping lane i over a window skewed i cycles from lane 0, then pulses
// weight_load so the PEs latch the shifted weights.
//   clk, reset   : clock, synchronous active-high reset
//   start        : drain one tile (sampled only in IDLE)
//   abort        : synchronous cancel back to IDLE, no done
//   fifo_empty   : per-lane FIFO empty flags
//   fifo_pop     : per-lane pop strobes (combinational)
//   fifo_to_arr  : array shifts the popped weights this cycle (combinational)
//   weight_load  : one-cycle latch pulse
//   busy         : high in DRAIN and LOAD
//   done         : one-cycle pulse with weight_load
module weight_fifo_drain_control
    import tpu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH_HEIGHT = DEFAULT_WIDTH_HEIGHT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [WIDTH_HEIGHT-1:0] fifo_empty,
    output logic [WIDTH_HEIGHT-1:0] fifo_pop,
    output logic                    fifo_to_arr,
    output logic                    weight_load,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned CNT_W    = cnt_width(WIDTH_HEIGHT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * WIDTH_HEIGHT - 2);

    drain_state_e            state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WIDTH_HEIGHT-1:0] want;
    logic                    stall;
    logic                    advance;

    skew_window_decode #(
        .WIDTH_HEIGHT (WIDTH_HEIGHT),
        .CNT_W        (CNT_W)
    ) u_window (
        .cnt    (cnt_q),
        .active (state_q == DRAIN),
        .want   (want)
    );

    // Any wanted lane that is empty freezes the whole wavefront.
    assign stall   = |(want & fifo_empty);
    assign advance = (state_q == DRAIN) && !stall;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter and output gating; outputs are forced low during reset.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fifo_pop    = '0;
        fifo_to_arr = 1'b0;
        weight_load = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                if (advance) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end

        if (!reset) begin
            fifo_pop    = advance ? want : '0;
            fifo_to_arr = advance;
            busy        = (state_q != IDLE);
            weight_load = (state_q == LOAD);
            done        = (state_q == LOAD);
        end
    end

endmodule
